// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 hex keypad emulator answering a column scan with the pressed key's row pattern.
// Optional contact bounce at the start of each press is enabled by defining KEYEMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int PRESS_CYCLES   = 64,
  parameter int RELEASE_CYCLES = 100_010,
  parameter int FIFO_DEPTH     = 4,
  parameter int BOUNCE_CYCLES  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic                          key_flush,
  input  logic [3:0]                    KEY_C,
  output logic [3:0]                    KEY_R,
  output logic                          pressed,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] P_LOAD = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] R_LOAD = CW'(RELEASE_CYCLES - 1);
`ifdef KEYEMU_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_code;
  logic          r_pressed;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_next_elapsed;
  logic          w_bounce_lvl;
  logic [7:0]    w_map;

  // Each entry is {column, row}; a 0 bit selects that line.
  function automatic logic [7:0] key_map(input logic [3:0] code);
    case (code)
      4'h0: key_map = 8'b1011_1110;
      4'h1: key_map = 8'b0111_0111;
      4'h2: key_map = 8'b1011_0111;
      4'h3: key_map = 8'b1101_0111;
      4'h4: key_map = 8'b0111_1011;
      4'h5: key_map = 8'b1011_1011;
      4'h6: key_map = 8'b1101_1011;
      4'h7: key_map = 8'b0111_1101;
      4'h8: key_map = 8'b1011_1101;
      4'h9: key_map = 8'b1101_1101;
      4'hA: key_map = 8'b1110_0111;
      4'hB: key_map = 8'b1110_1011;
      4'hC: key_map = 8'b1110_1101;
      4'hD: key_map = 8'b1110_1110;
      4'hE: key_map = 8'b0111_1110;
      default: key_map = 8'b1101_1110;
    endcase
  endfunction

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign key_ready  = !w_full;
  assign w_push     = key_valid && !w_full && !key_flush;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !key_flush;
  assign pressed    = r_pressed;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

  // Elapsed-in-PRESS count of the next cycle; bounce drives pressed from its bit 2.
  assign w_next_elapsed = CW'(PRESS_CYCLES) - r_cnt;
  assign w_bounce_lvl   = (w_next_elapsed < CW'(BOUNCE_CYCLES)) ? ~w_next_elapsed[2] : 1'b1;

  always_comb begin
    w_map = key_map(r_code);
    KEY_R = 4'hF;
    if (r_pressed && (KEY_C == w_map[7:4])) KEY_R = w_map[3:0];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= key_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_code    <= '0;
      r_pressed <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (key_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_code    <= r_mem[r_rd_ptr];
            r_cnt     <= P_LOAD;
            r_pressed <= 1'b1;
            r_state   <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (key_flush || (r_cnt == '0)) begin
            r_cnt     <= R_LOAD;
            r_pressed <= 1'b0;
            r_state   <= S_RELEASE;
          end else begin
            r_cnt     <= r_cnt - CW'(1);
            r_pressed <= BOUNCE_EN ? w_bounce_lvl : 1'b1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
